alu_op_sequencer: RTL

- Front-end controller for the 64-bit ALU and its result register.
- Accepts one operation request at a time over a valid/ready handshake and latches the operands.
- Drives the ALU operand buses and 5-bit op code, holds them for a per-op latency, then pulses the result-register enable.
- Captures the result and presents it on a valid/ready response port; illegal op codes are rejected with an error flag.

---
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU op sequencer.
// slave: the sequencer itself. master: requester + ALU + response consumer.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic        alu_enable;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, alu_enable,
               rsp_valid, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, alu_enable,
               rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the 64-bit ALU: accepts one op, drives the ALU for
// a per-op latency, pulses the result-register enable, returns the result.
// Optional build macro: ALU_SEQ_DIV0_TRAP_EN (trap divide-by-zero at accept).
module alu_op_sequencer #(
    parameter int unsigned BASIC_LAT = 1,
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_LAT   = 8
) (
    input  logic clk,
    input  logic clr,
    alu_op_sequencer_if.slave bus
);
    localparam int unsigned DW = 64;
    localparam int unsigned OW = 5;
    localparam int unsigned CW = 8;

    // A latency of 0 would never reach the final EXEC cycle, so run it as 1.
    localparam logic [CW-1:0] BASIC_CNT = (BASIC_LAT == 0) ? CW'(1) : CW'(BASIC_LAT);
    localparam logic [CW-1:0] MUL_CNT   = (MUL_LAT   == 0) ? CW'(1) : CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT   = (DIV_LAT   == 0) ? CW'(1) : CW'(DIV_LAT);

    localparam logic [OW-1:0] OP_MUL  = OW'(2);
    localparam logic [OW-1:0] OP_DIV  = OW'(3);
    localparam logic [OW-1:0] OP_LAST = OW'(11);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [OW-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          alu_enable_q, alu_enable_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] op_lat;

    // EXEC cycle count for the requested op.
    always_comb begin
        op_lat = BASIC_CNT;
        if (bus.req_op == OP_MUL) begin
            op_lat = MUL_CNT;
        end else if (bus.req_op == OP_DIV) begin
            op_lat = DIV_CNT;
        end
    end

    // Next-state and next-output logic; outputs are registered from *_d.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    alu_a_d    = bus.req_a;
                    alu_b_d    = bus.req_b;
                    alu_ctrl_d = bus.req_op;
                    if (bus.req_op > OP_LAST) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
`ifdef ALU_SEQ_DIV0_TRAP_EN
                    else if (bus.req_op == OP_DIV && bus.req_b == '0) begin
                        rsp_data_d = '1;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
`endif
                    else begin
                        cnt_d   = op_lat;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                rsp_data_d = bus.alu_result;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The enable is high while sitting in the final EXEC cycle.
        alu_enable_d = (state_d == EXEC) && (cnt_d == CW'(1));
        rsp_valid_d  = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // State, counter and output registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            alu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            alu_enable_q <= alu_enable_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.alu_enable = alu_enable_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = busy_q;
endmodule
